// File: rtl/ebus_arb_pkg.sv
// Shared EBUS arbitration types and defaults.
package ebus_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_DEMAND,
        ST_RELEASE,
        ST_DONE
    } ebus_state_e;

    localparam int unsigned EBUS_NREQ_DFLT    = 4;
    localparam int unsigned EBUS_TIMEOUT_DFLT = 32;

endpackage

// File: rtl/ebus_arb_rr_pick.sv
// Round-robin priority picker: first set req bit strictly after 'last', with wrap.
module ebus_arb_rr_pick
    import ebus_arb_pkg::*;
#(
    parameter int unsigned NREQ = EBUS_NREQ_DFLT,
    parameter int unsigned LW   = $clog2(EBUS_NREQ_DFLT)
) (
    input  logic [NREQ-1:0] req,
    input  logic [LW-1:0]   last,
    output logic [NREQ-1:0] winner_c
);

    logic          found;
    logic [LW-1:0] idx;

    always_comb begin
        winner_c = '0;
        found    = 1'b0;
        idx      = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            idx = LW'((32'(last) + i) % NREQ);
            if (!found && req[idx]) begin
                winner_c[idx] = 1'b1;
                found         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ebus_arb.sv
// EBUS arbiter: round-robin grant, demand/transfer handshake and no-response timeout.
module ebus_arb
    import ebus_arb_pkg::*;
#(
    parameter int unsigned NREQ    = EBUS_NREQ_DFLT,
    parameter int unsigned TIMEOUT = EBUS_TIMEOUT_DFLT
) (
    input  logic            clk60,
    input  logic            CROBAR,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic            demand,
    input  logic            xfer,
    output logic [NREQ-1:0] done,
    output logic            timeout,
    output logic            busy
);

    localparam int unsigned   LW      = $clog2(NREQ);
    localparam int unsigned   CW      = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    ebus_state_e     state, state_nx;
    logic [CW-1:0]   count, count_nx;
    logic [LW-1:0]   last, last_nx;
    logic [NREQ-1:0] grant_nx, done_nx;
    logic            demand_nx, timeout_nx, busy_nx;
    logic [NREQ-1:0] pick_c;
    logic [LW-1:0]   pick_idx;

    ebus_arb_rr_pick #(
        .NREQ (NREQ),
        .LW   (LW)
    ) u_rr_pick (
        .req      (req),
        .last     (last),
        .winner_c (pick_c)
    );

    // Index of the one-hot winner, for the round-robin pointer.
    always_comb begin
        pick_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick_c[i]) pick_idx = LW'(i);
        end
    end

    always_ff @(posedge clk60) begin
        if (CROBAR) begin
            state   <= ST_IDLE;
            grant   <= '0;
            demand  <= 1'b0;
            done    <= '0;
            timeout <= 1'b0;
            busy    <= 1'b0;
            count   <= '0;
            last    <= LW'(NREQ - 1);
        end else begin
            state   <= state_nx;
            grant   <= grant_nx;
            demand  <= demand_nx;
            done    <= done_nx;
            timeout <= timeout_nx;
            busy    <= busy_nx;
            count   <= count_nx;
            last    <= last_nx;
        end
    end

    // Next-state and registered-output values; done/timeout are single-cycle.
    always_comb begin
        state_nx   = state;
        grant_nx   = grant;
        demand_nx  = 1'b0;
        done_nx    = '0;
        timeout_nx = 1'b0;
        count_nx   = count;
        last_nx    = last;

        case (state)
            ST_IDLE: begin
                if (|req) begin
                    grant_nx = pick_c;
                    last_nx  = pick_idx;
                    state_nx = ST_GRANT;
                end
            end
            ST_GRANT: begin
                demand_nx = 1'b1;
                count_nx  = '0;
                state_nx  = ST_DEMAND;
            end
            ST_DEMAND: begin
                if (xfer) begin
                    count_nx = '0;
                    state_nx = ST_RELEASE;
                end else if (count == CNT_MAX) begin
                    done_nx    = grant;
                    timeout_nx = 1'b1;
                    state_nx   = ST_DONE;
                end else begin
                    demand_nx = 1'b1;
                    count_nx  = count + CW'(1);
                end
            end
            ST_RELEASE: begin
                if (!xfer) begin
                    done_nx  = grant;
                    state_nx = ST_DONE;
                end else if (count == CNT_MAX) begin
                    done_nx    = grant;
                    timeout_nx = 1'b1;
                    state_nx   = ST_DONE;
                end else begin
                    count_nx = count + CW'(1);
                end
            end
            ST_DONE: begin
                grant_nx = '0;
                state_nx = ST_IDLE;
            end
            default: begin
                grant_nx = '0;
                state_nx = ST_IDLE;
            end
        endcase

        busy_nx = (state_nx != ST_IDLE);
    end

endmodule

// File: tb/tb_ebus_arb.sv
// Randomized bench for ebus_arb against a transaction-level timing model.
module tb_ebus_arb;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 32;
    localparam int NEVER   = 1000;

    logic            clk60 = 1'b0;
    logic            CROBAR;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] grant;
    logic            demand;
    logic            xfer;
    logic [NREQ-1:0] done;
    logic            timeout;
    logic            busy;

    int n_checks = 0;
    int n_errors = 0;
    int last_m;

    ebus_arb #(
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk60   (clk60),
        .CROBAR  (CROBAR),
        .req     (req),
        .grant   (grant),
        .demand  (demand),
        .xfer    (xfer),
        .done    (done),
        .timeout (timeout),
        .busy    (busy)
    );

    always #5 clk60 = ~clk60;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk60);
        #1;
    endtask

    task automatic chk_bus(input string tag, input logic [NREQ-1:0] g, input logic d,
                           input logic [NREQ-1:0] dn, input logic t, input logic b);
        check({tag, ".grant"},   32'(grant),   32'(g));
        check({tag, ".demand"},  32'(demand),  32'(d));
        check({tag, ".done"},    32'(done),    32'(dn));
        check({tag, ".timeout"}, 32'(timeout), 32'(t));
        check({tag, ".busy"},    32'(busy),    32'(b));
    endtask

    // First requester after lst, wrapping.
    function automatic int rr_winner(input logic [NREQ-1:0] r, input int lst);
        for (int i = 1; i <= NREQ; i++) begin
            if (r[(lst + i) % NREQ]) return (lst + i) % NREQ;
        end
        return 0;
    endfunction

    task automatic do_reset(input int ncyc);
        CROBAR = 1'b1;
        req    = '0;
        xfer   = 1'b0;
        for (int i = 0; i < ncyc; i++) tick();
        chk_bus("reset", '0, 1'b0, '0, 1'b0, 1'b0);
        CROBAR = 1'b0;
        last_m = NREQ - 1;
    endtask

    // One transaction from an IDLE cycle. The device raises xfer a cycles after
    // demand first appears and holds it h cycles (a >= TIMEOUT: never).
    task automatic run_txn(input int a, input int h, input logic [NREQ-1:0] add,
                           input bit keep, input bit drop_mid);
        int w, dlen, rlen, total;
        logic tmo;
        logic [NREQ-1:0] oh;

        chk_bus("idle", '0, 1'b0, '0, 1'b0, 1'b0);
        req = req | add;
        if (req == '0) req = NREQ'(1) << $urandom_range(NREQ - 1);
        w  = rr_winner(req, last_m);
        oh = NREQ'(1) << w;
        if (a >= TIMEOUT) begin
            dlen = TIMEOUT;
            rlen = 0;
            tmo  = 1'b1;
        end else begin
            dlen = a + 1;
            rlen = (h < TIMEOUT) ? h : TIMEOUT;
            tmo  = (h > TIMEOUT);
        end
        total = dlen + rlen;
        xfer  = 1'($urandom_range(1));
        tick();

        chk_bus("grant", oh, 1'b0, '0, 1'b0, 1'b1);
        last_m = w;
        xfer   = 1'($urandom_range(1));
        req    = req | (NREQ'($urandom) & ~oh);
        tick();

        for (int k = 0; k < total; k++) begin
            chk_bus("hshake", oh, (k < dlen), '0, 1'b0, 1'b1);
            if (drop_mid && k == 0) req = req & ~oh;
            xfer = (k >= a) && (k < a + h);
            if ($urandom_range(7) == 0) req = req | (NREQ'($urandom) & ~oh);
            tick();
        end

        chk_bus("done", oh, 1'b0, oh, tmo, 1'b1);
        xfer = 1'b0;
        if (!keep) req = req & ~oh;
        tick();
    endtask

    initial begin
        int a, h;
        CROBAR = 1'b1;
        req    = '0;
        xfer   = 1'b0;
        last_m = NREQ - 1;
        do_reset(3);

        // Single master, normal handshake.
        run_txn(1, 1, NREQ'(1), 1'b0, 1'b0);

        // Reset while in DEMAND: bus released with no done, pointer back to NREQ-1.
        req = NREQ'(4);
        chk_bus("rst_idle", '0, 1'b0, '0, 1'b0, 1'b0);
        tick();
        chk_bus("rst_grant", NREQ'(4), 1'b0, '0, 1'b0, 1'b1);
        tick();
        chk_bus("rst_demand", NREQ'(4), 1'b1, '0, 1'b0, 1'b1);
        CROBAR = 1'b1;
        req    = '0;
        tick();
        chk_bus("rst_mid", '0, 1'b0, '0, 1'b0, 1'b0);
        CROBAR = 1'b0;
        last_m = NREQ - 1;
        tick();
        chk_bus("rst_after", '0, 1'b0, '0, 1'b0, 1'b0);
        run_txn(1, 1, NREQ'(2), 1'b0, 1'b0);

        // All requesters held: grants rotate 0,1,2,3,0.
        do_reset(1);
        for (int i = 0; i < NREQ + 1; i++) run_txn(1, 1, '1, 1'b1, 1'b0);
        req = '0;

        // Device silent: demand timeout.
        run_txn(NEVER, 1, NREQ'(4), 1'b0, 1'b0);
        // xfer stuck high: release timeout.
        run_txn(1, NEVER, NREQ'(8), 1'b0, 1'b0);
        // Owner drops req mid-transaction.
        run_txn(1, 1, NREQ'(2), 1'b0, 1'b1);
        // Boundary: xfer arrives in the last demand cycle, release ends exactly at the limit.
        run_txn(TIMEOUT - 1, TIMEOUT, NREQ'(1), 1'b0, 1'b0);

        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(5))
                0, 1, 2: a = $urandom_range(3);
                3:       a = TIMEOUT - 2 + $urandom_range(3);
                default: a = NEVER;
            endcase
            case ($urandom_range(5))
                0, 1, 2: h = 1 + $urandom_range(2);
                3:       h = TIMEOUT - 1 + $urandom_range(2);
                default: h = NEVER;
            endcase
            if (req == '0) begin
                xfer = 1'($urandom_range(1));
                tick();
            end
            run_txn(a, h, NREQ'($urandom), 1'($urandom_range(1)), ($urandom_range(3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
